mem_port_arbiter: RTL

- Shares one single-port instruction/data memory between the fetch stage (read-only) and the execute stage (load/store).
- Sits between the core's fetch/execute memory requests and the memory model.
- Runs one transaction at a time with a req/gnt/rvalid handshake.
- Fixed data-over-fetch priority, with a starvation guard so fetch is always eventually served.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port memory between fetch (read-only) and execute (load/store).
// Latency : gnt 1 cycle after a request is seen in IDLE; read rvalid MEM_LAT+2 cycles after that cycle.
// Backpressure: one transaction in flight; requests are sampled only in IDLE, so req is held until gnt.
// Ports   : clk, rst (async active-low); fetch side if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//           data side d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata; memory side mem_addr/
//           mem_wdata/mem_we/mem_re <- mem_rdata; busy is high in every state except IDLE.
// Option  : define ARB_ROUND_ROBIN_EN to replace data priority + starvation guard with a two-way
//           round robin (last-granted pointer resets to data, so fetch wins the first tie).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} stateT;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  stateT      state;
  logic       ownerData;   // 1 = current transaction belongs to the data port
  logic       opWrite;     // current transaction is a store
  logic [3:0] latCnt;      // remaining WAIT cycles, including the one being counted
  logic       grantData;   // arbitration result for this IDLE cycle
  logic       anyReq;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastData;          // 1 = data port was granted last

  // On a tie the port not granted last wins; a lone requester always wins.
  assign grantData = d_req & ~(if_req & lastData);
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starveCnt;   // data grants issued in a row while fetch was waiting

  // Data wins unless fetch has already been passed over STARVE_MAX times.
  assign grantData = d_req & ~(if_req & (starveCnt == STARVE_LIM));
`endif

  assign anyReq = if_req | d_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ownerData <= 1'b0;
      opWrite   <= 1'b0;
      latCnt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastData  <= 1'b1;
`else
      starveCnt <= '0;
`endif
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Single-cycle pulses default low; each state raises only what it owns.
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;

      case (state)
        IDLE: begin
          if (anyReq) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            ownerData <= grantData;
            opWrite   <= grantData & d_we;
            // Gnt and strobes are registered here so they appear during ACCESS.
            if_gnt    <= ~grantData;
            d_gnt     <= grantData;
            mem_we    <= grantData & d_we;
            mem_re    <= ~(grantData & d_we);
            mem_addr  <= grantData ? d_addr : if_addr;
            // Fetch carries no write data, so mem_wdata keeps its last value.
            if (grantData) begin
              mem_wdata <= d_wdata;
            end
`ifdef ARB_ROUND_ROBIN_EN
            lastData  <= grantData;
`else
            if (grantData && if_req) begin
              starveCnt <= (starveCnt == STARVE_LIM) ? STARVE_LIM : starveCnt + 4'd1;
            end else begin
              starveCnt <= '0;
            end
`endif
          end
        end

        ACCESS: begin
          if (opWrite) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state  <= WAIT;
            latCnt <= LAT_LOAD;
          end
        end

        WAIT: begin
          // mem_rdata is valid in the last WAIT cycle; capture it and raise rvalid for RESP.
          if (latCnt == 4'd1) begin
            state <= RESP;
            if (ownerData) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            latCnt <= latCnt - 4'd1;
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
